// File: rtl/lenet_pkg.sv
// Shared sizing, types and FSM encoding for the LeNet5 front-end blocks.
package lenet_pkg;

  localparam int unsigned DATA_WIDTH  = 16;
  localparam int unsigned IMG_W       = 32;
  localparam int unsigned IMG_H       = 32;
  localparam int unsigned K           = 5;
  localparam int unsigned MEM_LATENCY = 2;

  localparam int unsigned OUT_W = IMG_W - K + 1;
  localparam int unsigned OUT_H = IMG_H - K + 1;
  localparam int unsigned NPIX  = IMG_W * IMG_H;

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam int unsigned CNT_W = $clog2(NPIX);
  localparam int unsigned POS_W = $clog2((OUT_H > OUT_W) ? OUT_H : OUT_W);
  localparam int unsigned WIN_W = K * K * DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef logic [DATA_WIDTH-1:0] pixel_t;

  // Element [r][c] lands at bits (r*K+c)*DATA_WIDTH, r=0 top, c=0 left.
  typedef logic [K-1:0][K-1:0][DATA_WIDTH-1:0] window_t;

  // Stored column entries, index 0 = most recent previous row.
  typedef logic [K-2:0][DATA_WIDTH-1:0] lb_col_t;

endpackage

// File: rtl/conv1_window_gen_if.sv
// Image-memory read bus, control handshake and window output bundle.
interface conv1_window_gen_if;
  import lenet_pkg::*;

  logic               loadfull;
  logic               start;
  logic               read;
  pixel_t             PixelIn;
  logic [WIN_W-1:0]   window;
  logic               window_valid;
  logic [POS_W-1:0]   out_row;
  logic [POS_W-1:0]   out_col;
  logic               busy;
  logic               done;

  // Window generator side.
  modport slave (
    input  loadfull, start, PixelIn,
    output read, window, window_valid, out_row, out_col, busy, done
  );

  // Memory / controller / consumer side.
  modport master (
    output loadfull, start, PixelIn,
    input  read, window, window_valid, out_row, out_col, busy, done
  );

endinterface

// File: rtl/conv_line_buffer.sv
// K-1 image rows indexed by column; a write pushes the column down one row.
module conv_line_buffer
  import lenet_pkg::*;
(
  input  logic             clk,
  input  logic             wr_en,
  input  logic [COL_W-1:0] col,
  input  pixel_t           din,
  output lb_col_t          col_data
);

  pixel_t mem [K-1][IMG_W];

  // Shift-down write: row 0 takes the new pixel, older rows move one deeper.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[0][col] <= din;
      for (int i = 1; i < int'(K) - 1; i++) begin
        mem[i][col] <= mem[i-1][col];
      end
    end
  end

  // Combinational read of the stored column at the current write position.
  always_comb begin
    col_data = '0;
    for (int i = 0; i < int'(K) - 1; i++) begin
      col_data[i] = mem[i][col];
    end
  end

endmodule

// File: rtl/conv1_window_gen.sv
// Streams a 32x32 frame out of the image memory and emits 5x5 sliding windows.
module conv1_window_gen
  import lenet_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  conv1_window_gen_if.slave bus
);

  state_t                      state;
  state_t                      state_nxt;
  logic [CNT_W-1:0]            issue_cnt;
  logic [MEM_LATENCY-1:0]      rd_pipe;
  logic [COL_W-1:0]            in_col;
  logic [ROW_W-1:0]            in_row;

  logic                        accept_c;
  logic                        issue_last_c;
  logic                        scan_start_c;
  logic                        win_ready_c;
  lb_col_t                     lb_col_c;
  logic [K-1:0][DATA_WIDTH-1:0] new_col_c;

  window_t                     win;
  logic                        win_valid;
  logic [POS_W-1:0]            row_pos;
  logic [POS_W-1:0]            col_pos;
  logic                        rd_strobe;
  logic                        busy_q;
  logic                        done_q;

  // A pixel is on PixelIn exactly MEM_LATENCY cycles after its read cycle.
  assign accept_c     = rd_pipe[MEM_LATENCY-1];
  assign issue_last_c = (issue_cnt == CNT_W'(NPIX - 1));
  assign scan_start_c = (state == ST_IDLE) && (state_nxt == ST_ISSUE);
  // Columns left over from the previous row stay hidden until K fresh ones shifted in.
  assign win_ready_c  = (in_row >= ROW_W'(K - 1)) && (in_col >= COL_W'(K - 1));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: issue the frame, drain the read pipeline, pulse done.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.start && !bus.loadfull) state_nxt = ST_ISSUE;
      ST_ISSUE: if (issue_last_c)               state_nxt = ST_DRAIN;
      ST_DRAIN: if (rd_pipe == '0)              state_nxt = ST_DONE;
      ST_DONE:                                  state_nxt = ST_IDLE;
      default:                                  state_nxt = ST_IDLE;
    endcase
  end

  // Registered strobes derived from the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_strobe <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rd_strobe <= (state_nxt != ST_ISSUE);
      busy_q    <= (state_nxt == ST_ISSUE) || (state_nxt == ST_DRAIN);
      done_q    <= (state_nxt == ST_DONE);
    end
  end

  // Issue counter: one address per ISSUE cycle, parked at zero otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_cnt <= '0;
    end else if (state == ST_ISSUE) begin
      issue_cnt <= issue_cnt + CNT_W'(1);
    end else begin
      issue_cnt <= '0;
    end
  end

  // Read-issued flags travelling alongside the memory latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe <= (rd_pipe << 1) | MEM_LATENCY'(state == ST_ISSUE);
    end
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_col <= '0;
      in_row <= '0;
    end else if (scan_start_c) begin
      in_col <= '0;
      in_row <= '0;
    end else if (accept_c) begin
      if (in_col == COL_W'(IMG_W - 1)) begin
        in_col <= '0;
        in_row <= in_row + ROW_W'(1);
      end else begin
        in_col <= in_col + COL_W'(1);
      end
    end
  end

  conv_line_buffer u_line_buffer (
    .clk      (clk),
    .wr_en    (accept_c),
    .col      (in_col),
    .din      (bus.PixelIn),
    .col_data (lb_col_c)
  );

  // Incoming column, top to bottom: oldest buffered row down to the live pixel.
  always_comb begin
    new_col_c      = '0;
    new_col_c[K-1] = bus.PixelIn;
    for (int r = 0; r < int'(K) - 1; r++) begin
      new_col_c[r] = lb_col_c[int'(K) - 2 - r];
    end
  end

  // Window register: shift left, load the new column on the right.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win <= '0;
    end else if (accept_c) begin
      for (int r = 0; r < int'(K); r++) begin
        for (int c = 0; c < int'(K) - 1; c++) begin
          win[r][c] <= win[r][c+1];
        end
        win[r][K-1] <= new_col_c[r];
      end
    end
  end

  // Valid flag and output coordinates, aligned with the window register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_valid <= 1'b0;
      row_pos   <= '0;
      col_pos   <= '0;
    end else begin
      win_valid <= accept_c && win_ready_c;
      if (accept_c && win_ready_c) begin
        row_pos <= POS_W'(in_row - ROW_W'(K - 1));
        col_pos <= POS_W'(in_col - COL_W'(K - 1));
      end
    end
  end

  assign bus.read         = rd_strobe;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.window       = win;
  assign bus.window_valid = win_valid;
  assign bus.out_row      = row_pos;
  assign bus.out_col      = col_pos;

endmodule

// File: tb/tb_conv1_window_gen.sv
// Frame-level bench: latency-2 image memory model plus a per-cycle window reference.
module tb_conv1_window_gen;
  import lenet_pkg::*;

  localparam int unsigned WW        = WIN_W;
  localparam int          DONE_CYC  = int'(NPIX) + int'(MEM_LATENCY) + 1;

  logic clk = 1'b0;
  logic rst;

  conv1_window_gen_if bus ();

  conv1_window_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_errors = 0;
  pixel_t img [NPIX];

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Window whose top-left pixel sits at image (r0, c0).
  function automatic logic [WW-1:0] exp_window(input int r0, input int c0);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < int'(K); i++) begin
      for (int j = 0; j < int'(K); j++) begin
        w[(i*int'(K)+j)*int'(DATA_WIDTH) +: DATA_WIDTH] =
          img[CNT_W'((r0 + i) * int'(IMG_W) + c0 + j)];
      end
    end
    return w;
  endfunction

  // Pixel p (read in cycle p) completes a window at cycle p+MEM_LATENCY+1
  // when it is at least K-1 rows and columns into the image.
  function automatic bit exp_valid(input int cyc);
    int t;
    t = cyc - int'(MEM_LATENCY) - 1;
    if (t < 0 || t >= int'(NPIX)) return 1'b0;
    return (t / int'(IMG_W) >= int'(K) - 1) && (t % int'(IMG_W) >= int'(K) - 1);
  endfunction

  // pattern: 0 = address, 1 = 1023-address, other = random.
  // abort_at >= 0 asserts reset in that cycle; extra_start_at pulses start mid-scan.
  task automatic run_frame(input int pattern, input int abort_at, input int extra_start_at);
    int     addr;
    int     n_valid;
    int     n_read_low;
    int     n_done;
    int     done_cyc;
    int     t;
    int     r0;
    int     c0;
    bit     ev;
    pixel_t p1;
    pixel_t p2;

    for (int i = 0; i < int'(NPIX); i++) begin
      case (pattern)
        0:       img[i] = DATA_WIDTH'(i);
        1:       img[i] = DATA_WIDTH'(int'(NPIX) - 1 - i);
        default: img[i] = DATA_WIDTH'($urandom);
      endcase
    end
    addr = 0; n_valid = 0; n_read_low = 0; n_done = 0; done_cyc = -1;
    p1 = '0; p2 = '0;

    bus.loadfull = 1'b0;
    bus.start    = 1'b1;
    @(negedge clk);

    for (int cyc = 0; cyc <= DONE_CYC; cyc++) begin
      if (!bus.read) n_read_low++;
      check("read", WW'(bus.read), WW'(cyc >= int'(NPIX)));
      check("busy", WW'(bus.busy), WW'(cyc < DONE_CYC));
      check("done", WW'(bus.done), WW'(cyc == DONE_CYC));
      if (bus.done) begin
        n_done++;
        done_cyc = cyc;
      end
      ev = exp_valid(cyc);
      check("window_valid", WW'(bus.window_valid), WW'(ev));
      if (bus.window_valid) n_valid++;
      if (bus.window_valid && ev) begin
        t  = cyc - int'(MEM_LATENCY) - 1;
        r0 = t / int'(IMG_W) - (int'(K) - 1);
        c0 = t % int'(IMG_W) - (int'(K) - 1);
        check("out_row", WW'(bus.out_row), WW'(r0));
        check("out_col", WW'(bus.out_col), WW'(c0));
        check("window", WW'(bus.window), exp_window(r0, c0));
      end

      // Memory: a read seen in cycle t drives PixelIn from mid t+2 through the t+2 edge.
      bus.PixelIn = p2;
      p2 = p1;
      if (!bus.read && addr < int'(NPIX)) begin
        p1 = img[CNT_W'(addr)];
        addr++;
      end else begin
        p1 = DATA_WIDTH'($urandom);
      end

      bus.start = (cyc == extra_start_at);

      if (cyc == abort_at) begin
        rst = 1'b0;
        #1;
        check("abort_read", WW'(bus.read), WW'(1));
        check("abort_busy", WW'(bus.busy), WW'(0));
        check("abort_valid", WW'(bus.window_valid), WW'(0));
        check("abort_done", WW'(bus.done), WW'(0));
        check("abort_window", WW'(bus.window), WW'(0));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end

    check("n_windows", WW'(n_valid), WW'(OUT_W * OUT_H));
    check("n_read_low", WW'(n_read_low), WW'(NPIX));
    check("n_done", WW'(n_done), WW'(1));
    check("done_cycle", WW'(done_cyc), WW'(DONE_CYC));
  endtask

  initial begin
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.loadfull = 1'b1;
    bus.PixelIn  = '0;

    // Held in reset, start pulses must have no effect.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.loadfull = 1'b0;
      bus.start    = i[0];
      check("rst_read", WW'(bus.read), WW'(1));
      check("rst_busy", WW'(bus.busy), WW'(0));
      check("rst_done", WW'(bus.done), WW'(0));
      check("rst_valid", WW'(bus.window_valid), WW'(0));
      check("rst_window", WW'(bus.window), WW'(0));
    end
    check("rst_out_row", WW'(bus.out_row), WW'(0));
    check("rst_out_col", WW'(bus.out_col), WW'(0));
    bus.start    = 1'b0;
    bus.loadfull = 1'b1;
    @(negedge clk);
    rst = 1'b1;

    // Image not loaded: start is ignored.
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("noload_read", WW'(bus.read), WW'(1));
      check("noload_busy", WW'(bus.busy), WW'(0));
      @(negedge clk);
    end

    run_frame(0, -1, -1);
    repeat (2) @(negedge clk);
    run_frame(0, 500, -1);
    run_frame(0, -1, 300);
    run_frame(1, -1, -1);
    run_frame(2, -1, -1);
    repeat (3) @(negedge clk);
    run_frame(2, -1, 777);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
